// File: rtl/aes_block_sequencer.sv
`timescale 1ns/1ps
// aes_block_sequencer
// Control sequencer for the AES HWPE. Walks a byte buffer block by block:
// optional key expansion, word-wise fetch through the source streamer, core
// start, word-wise store through the sink streamer. The final block may be
// partial; a zero-length job finishes immediately with an error pulse.
//
// Ports:
//   clk, reset_n (async, active-low), clear_i (sync abort to IDLE)
//   start_i, key_reuse_i, in_base_i, out_base_i, byte_len_i  : job setup
//   src_req_o/src_addr_o/src_done_i                          : source streamer
//   sink_req_o/sink_addr_o/sink_done_i, data_out_valid_o     : sink streamer
//   word_idx_o                                               : word within block
//   core_init_key_o, core_start_o, core_ready_i              : AES core
//   engine_clear_o                                           : engine buffer clear
//   busy_o, done_o, err_o, blocks_done_o                     : status
module aes_block_sequencer #(
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int WORD_BYTES      = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               clear_i,
   input  logic                               start_i,
   input  logic                               key_reuse_i,
   input  logic [ADDR_W-1:0]                  in_base_i,
   input  logic [ADDR_W-1:0]                  out_base_i,
   input  logic [LEN_W-1:0]                   byte_len_i,
   output logic                               src_req_o,
   output logic [ADDR_W-1:0]                  src_addr_o,
   input  logic                               src_done_i,
   output logic                               sink_req_o,
   output logic [ADDR_W-1:0]                  sink_addr_o,
   input  logic                               sink_done_i,
   output logic [$clog2(WORDS_PER_BLOCK):0]   word_idx_o,
   output logic                               core_init_key_o,
   output logic                               core_start_o,
   input  logic                               core_ready_i,
   output logic                               data_out_valid_o,
   output logic                               engine_clear_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o,
   output logic [LEN_W-1:0]                   blocks_done_o
);

   localparam int IW    = $clog2(WORDS_PER_BLOCK) + 1;
   localparam int BB    = WORDS_PER_BLOCK * WORD_BYTES;
   localparam int BB_SH = $clog2(BB);
   localparam int WB_SH = $clog2(WORD_BYTES);

   typedef enum logic [3:0] {
      IDLE, KEY_INIT, KEY_WAIT, FETCH_REQ, FETCH_WAIT, CORE_START,
      CORE_WAIT, STORE_REQ, STORE_WAIT, BLOCK_DONE, FINISH
   } state_t;

   state_t            state_reg, state_next;
   logic [IW-1:0]     idx_reg, idx_next;
   logic [LEN_W-1:0]  blocks_reg, blocks_next;
   logic [LEN_W-1:0]  rem_reg, rem_next;
   logic [ADDR_W-1:0] in_base_reg, in_base_next;
   logic [ADDR_W-1:0] out_base_reg, out_base_next;
   logic              zero_len_reg, zero_len_next;
   logic              guard_reg, guard_next;
   logic              done_next, err_next;

   // Words in the current block; remaining only changes between blocks,
   // so this is stable for the whole block.
   logic [LEN_W-1:0]  rem_ceil;
   logic [IW-1:0]     nw;
   assign rem_ceil = (rem_reg + LEN_W'(WORD_BYTES - 1)) >> WB_SH;
   assign nw       = (rem_reg >= LEN_W'(BB)) ? IW'(WORDS_PER_BLOCK) : IW'(rem_ceil);

   logic [ADDR_W-1:0] offset_next;
   assign offset_next = (ADDR_W'(blocks_next) << BB_SH) + (ADDR_W'(idx_next) << WB_SH);

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      blocks_next   = blocks_reg;
      rem_next      = rem_reg;
      in_base_next  = in_base_reg;
      out_base_next = out_base_reg;
      zero_len_next = zero_len_reg;
      guard_next    = 1'b0;
      done_next     = 1'b0;
      err_next      = 1'b0;
      if (clear_i) begin
         state_next    = IDLE;
         idx_next      = '0;
         blocks_next   = '0;
         rem_next      = '0;
         zero_len_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (start_i) begin
               in_base_next  = in_base_i;
               out_base_next = out_base_i;
               rem_next      = byte_len_i;
               blocks_next   = '0;
               idx_next      = '0;
               zero_len_next = (byte_len_i == '0);
               if (byte_len_i == '0)  state_next = FINISH;
               else if (key_reuse_i)  state_next = FETCH_REQ;
               else                   state_next = KEY_INIT;
            end
            KEY_INIT: begin
               state_next = KEY_WAIT;
               guard_next = 1'b1;
            end
            // First wait cycle ignores core_ready_i: the core may not yet
            // have dropped ready in response to the pulse.
            KEY_WAIT: if (!guard_reg && core_ready_i) state_next = FETCH_REQ;
            FETCH_REQ, FETCH_WAIT: begin
               if (src_done_i) begin
                  if (idx_reg + IW'(1) == nw) begin
                     idx_next   = '0;
                     state_next = CORE_START;
                  end else begin
                     idx_next   = idx_reg + IW'(1);
                     state_next = FETCH_REQ;
                  end
               end else begin
                  state_next = FETCH_WAIT;
               end
            end
            CORE_START: begin
               state_next = CORE_WAIT;
               guard_next = 1'b1;
            end
            CORE_WAIT: if (!guard_reg && core_ready_i) state_next = STORE_REQ;
            STORE_REQ, STORE_WAIT: begin
               if (sink_done_i) begin
                  if (idx_reg + IW'(1) == nw) begin
                     idx_next   = '0;
                     state_next = BLOCK_DONE;
                  end else begin
                     idx_next   = idx_reg + IW'(1);
                     state_next = STORE_REQ;
                  end
               end else begin
                  state_next = STORE_WAIT;
               end
            end
            BLOCK_DONE: begin
               blocks_next = blocks_reg + LEN_W'(1);
               rem_next    = (rem_reg >= LEN_W'(BB)) ? rem_reg - LEN_W'(BB) : '0;
               idx_next    = '0;
               state_next  = (rem_next == '0) ? FINISH : FETCH_REQ;
            end
            FINISH: begin
               done_next  = 1'b1;
               err_next   = zero_len_reg;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the
   // state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         blocks_reg       <= '0;
         rem_reg          <= '0;
         in_base_reg      <= '0;
         out_base_reg     <= '0;
         zero_len_reg     <= 1'b0;
         guard_reg        <= 1'b0;
         src_req_o        <= 1'b0;
         src_addr_o       <= '0;
         sink_req_o       <= 1'b0;
         sink_addr_o      <= '0;
         data_out_valid_o <= 1'b0;
         core_init_key_o  <= 1'b0;
         core_start_o     <= 1'b0;
         engine_clear_o   <= 1'b1;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         err_o            <= 1'b0;
      end else begin
         state_reg        <= state_next;
         idx_reg          <= idx_next;
         blocks_reg       <= blocks_next;
         rem_reg          <= rem_next;
         in_base_reg      <= in_base_next;
         out_base_reg     <= out_base_next;
         zero_len_reg     <= zero_len_next;
         guard_reg        <= guard_next;
         src_req_o        <= (state_next == FETCH_REQ) || (state_next == FETCH_WAIT);
         src_addr_o       <= ((state_next == FETCH_REQ) || (state_next == FETCH_WAIT))
                             ? in_base_next + offset_next : '0;
         sink_req_o       <= (state_next == STORE_REQ) || (state_next == STORE_WAIT);
         data_out_valid_o <= (state_next == STORE_REQ) || (state_next == STORE_WAIT);
         sink_addr_o      <= ((state_next == STORE_REQ) || (state_next == STORE_WAIT))
                             ? out_base_next + offset_next : '0;
         core_init_key_o  <= (state_next == KEY_INIT);
         core_start_o     <= (state_next == CORE_START);
         engine_clear_o   <= (state_next == IDLE) || (state_next == BLOCK_DONE);
         busy_o           <= (state_next != IDLE);
         done_o           <= done_next;
         err_o            <= err_next;
      end
   end

   assign word_idx_o    = idx_reg;
   assign blocks_done_o = blocks_reg;

endmodule

// File: tb/tb_aes_block_sequencer.sv
`timescale 1ns/1ps
// Directed bench for aes_block_sequencer with streamer and core responders.
module tb_aes_block_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear_i, start_i, key_reuse_i;
   logic [31:0] in_base_i, out_base_i, byte_len_i;
   logic        src_req_o, sink_req_o, src_done_i, sink_done_i;
   logic [31:0] src_addr_o, sink_addr_o, blocks_done_o;
   logic [2:0]  word_idx_o;
   logic        core_init_key_o, core_start_o, data_out_valid_o;
   logic        engine_clear_o, busy_o, done_o, err_o;
   logic        core_ready_i = 1'b1;

   aes_block_sequencer dut (
      .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .start_i(start_i),
      .key_reuse_i(key_reuse_i), .in_base_i(in_base_i), .out_base_i(out_base_i),
      .byte_len_i(byte_len_i), .src_req_o(src_req_o), .src_addr_o(src_addr_o),
      .src_done_i(src_done_i), .sink_req_o(sink_req_o), .sink_addr_o(sink_addr_o),
      .sink_done_i(sink_done_i), .word_idx_o(word_idx_o),
      .core_init_key_o(core_init_key_o), .core_start_o(core_start_o),
      .core_ready_i(core_ready_i), .data_out_valid_o(data_out_valid_o),
      .engine_clear_o(engine_clear_o), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .blocks_done_o(blocks_done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus-controlled knobs
   logic log_clr = 1'b0;
   int src_stall_at = 99, src_stall_len = 0;
   int sink_stall_at = 99, sink_stall_len = 0;

   // Monitor state
   int src_cnt, sink_cnt, src_stall_used, sink_stall_used;
   int init_hi, start_hi, done_cnt, err_cnt, err_with_done;
   int src_req_hi, sink_req_hi, stall_hold, unstable;
   int first_src_cyc, done_cyc;
   logic [31:0] src_log[$];
   logic [31:0] sink_log[$];
   logic prev_src_req = 1'b0, prev_src_go = 1'b0;
   logic [31:0] prev_src_addr = '0;
   int core_busy = 0;

   logic src_go, sink_go;
   assign src_go  = src_req_o  && !(src_cnt  == src_stall_at  && src_stall_used  < src_stall_len);
   assign sink_go = sink_req_o && !(sink_cnt == sink_stall_at && sink_stall_used < sink_stall_len);

   always @(negedge clk) begin
      src_done_i    <= src_go;
      sink_done_i   <= sink_go;
      prev_src_req  <= src_req_o;
      prev_src_go   <= src_go;
      prev_src_addr <= src_addr_o;
      if (log_clr) begin
         src_cnt <= 0; sink_cnt <= 0; src_stall_used <= 0; sink_stall_used <= 0;
         init_hi <= 0; start_hi <= 0; done_cnt <= 0; err_cnt <= 0; err_with_done <= 0;
         src_req_hi <= 0; sink_req_hi <= 0; stall_hold <= 0; unstable <= 0;
         first_src_cyc <= -1; done_cyc <= -1;
         src_log.delete(); sink_log.delete();
      end else begin
         if (src_req_o) begin
            src_req_hi <= src_req_hi + 1;
            if (first_src_cyc < 0) first_src_cyc <= cyc;
            if (src_go) begin
               src_log.push_back(src_addr_o);
               src_cnt <= src_cnt + 1;
            end else begin
               src_stall_used <= src_stall_used + 1;
            end
            if (prev_src_req && !prev_src_go && src_addr_o != prev_src_addr)
               unstable <= unstable + 1;
            if (src_addr_o == 32'h1008 && word_idx_o == 3'd2)
               stall_hold <= stall_hold + 1;
         end
         if (sink_req_o) begin
            sink_req_hi <= sink_req_hi + 1;
            if (sink_go) begin
               sink_log.push_back(sink_addr_o);
               sink_cnt <= sink_cnt + 1;
            end else begin
               sink_stall_used <= sink_stall_used + 1;
            end
         end
         if (core_init_key_o) init_hi <= init_hi + 1;
         if (core_start_o)    start_hi <= start_hi + 1;
         if (done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (err_o) err_with_done <= err_with_done + 1;
         end
         if (err_o) err_cnt <= err_cnt + 1;
      end
   end

   // Core model: busy for a few cycles after each init/start pulse.
   always @(negedge clk) begin
      if (core_init_key_o || core_start_o) begin
         core_busy    <= 3;
         core_ready_i <= 1'b0;
      end else if (core_busy > 0) begin
         core_busy    <= core_busy - 1;
         core_ready_i <= (core_busy == 1);
      end else begin
         core_ready_i <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   int start_cyc;

   task automatic start_job(input logic kr, input logic [31:0] len);
      log_clr = 1'b1;
      step();
      log_clr     = 1'b0;
      key_reuse_i = kr;
      byte_len_i  = len;
      in_base_i   = 32'h1000;
      out_base_i  = 32'h2000;
      start_i     = 1'b1;
      start_cyc   = cyc;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
      repeat (4) step();
      check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      $display("job %s: len=%0d blocks=%0d src_words=%0d sink_words=%0d init=%0d starts=%0d",
               tag, byte_len_i, blocks_done_o, src_cnt, sink_cnt, init_hi, start_hi);
   endtask

   initial begin
      reset_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; key_reuse_i = 1'b0;
      in_base_i = '0; out_base_i = '0; byte_len_i = '0;
      repeat (3) step();
      check("rst_engine_clear", 64'(engine_clear_o), 64'd1);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_src_req", 64'(src_req_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_blocks", 64'(blocks_done_o), 64'd0);
      reset_n = 1'b1;
      step();

      // 64 bytes, full key init, zero-wait streamers
      start_job(1'b0, 32'd64);
      wait_done("t1");
      check("t1_init_pulses", 64'(init_hi), 64'd1);
      check("t1_core_starts", 64'(start_hi), 64'd4);
      check("t1_src_words", 64'(src_cnt), 64'd16);
      check("t1_sink_words", 64'(sink_cnt), 64'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t1_src_addr%0d", i), 64'(src_log[i]), 64'(32'h1000 + 4 * i));
         check($sformatf("t1_sink_addr%0d", i), 64'(sink_log[i]), 64'(32'h2000 + 4 * i));
      end
      check("t1_blocks", 64'(blocks_done_o), 64'd4);
      check("t1_err", 64'(err_cnt), 64'd0);
      check("t1_busy_after", 64'(busy_o), 64'd0);

      // 20 bytes: one full block plus a single-word tail
      start_job(1'b0, 32'd20);
      wait_done("t2");
      check("t2_src_words", 64'(src_cnt), 64'd5);
      check("t2_sink_words", 64'(sink_cnt), 64'd5);
      check("t2_src_tail", 64'(src_log[4]), 64'h1010);
      check("t2_sink_tail", 64'(sink_log[4]), 64'h2010);
      check("t2_core_starts", 64'(start_hi), 64'd2);
      check("t2_blocks", 64'(blocks_done_o), 64'd2);

      // zero length
      start_job(1'b0, 32'd0);
      wait_done("t3");
      check("t3_done_latency", 64'(done_cyc - start_cyc), 64'd2);
      check("t3_err_with_done", 64'(err_with_done), 64'd1);
      check("t3_err_pulses", 64'(err_cnt), 64'd1);
      check("t3_src_req", 64'(src_req_hi), 64'd0);
      check("t3_sink_req", 64'(sink_req_hi), 64'd0);
      check("t3_core_pulses", 64'(init_hi + start_hi), 64'd0);
      check("t3_blocks", 64'(blocks_done_o), 64'd0);

      // key reuse, one block
      start_job(1'b1, 32'd16);
      wait_done("t4");
      check("t4_init_pulses", 64'(init_hi), 64'd0);
      check("t4_first_src", 64'(first_src_cyc - start_cyc), 64'd1);
      check("t4_src_words", 64'(src_cnt), 64'd4);
      check("t4_blocks", 64'(blocks_done_o), 64'd1);

      // source stall of 5 cycles on word 2
      src_stall_at = 2; src_stall_len = 5;
      start_job(1'b1, 32'd16);
      wait_done("t5");
      src_stall_len = 0;
      check("t5_stall_hold", 64'(stall_hold), 64'd6);
      check("t5_unstable", 64'(unstable), 64'd0);
      check("t5_src_words", 64'(src_cnt), 64'd4);
      check("t5_src_addr3", 64'(src_log[3]), 64'h100C);
      check("t5_sink_words", 64'(sink_cnt), 64'd4);

      // clear during STORE_WAIT of block 1
      sink_stall_at = 5; sink_stall_len = 1000;
      start_job(1'b0, 32'd64);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 3000 && seen < 2; i++) begin
            step();
            if (sink_req_o && sink_addr_o == 32'h2014) seen++;
         end
         check("t6_reached_store_wait", 64'(seen), 64'd2);
      end
      check("t6_blocks_before", 64'(blocks_done_o), 64'd1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("t6_sink_req_dropped", 64'(sink_req_o), 64'd0);
      check("t6_busy", 64'(busy_o), 64'd0);
      check("t6_blocks_cleared", 64'(blocks_done_o), 64'd0);
      sink_stall_len = 0;
      repeat (6) step();
      check("t6_no_done", 64'(done_cnt), 64'd0);
      $display("job t6: cleared during store, done pulses=%0d", done_cnt);
      start_job(1'b0, 32'd16);
      wait_done("t6b");
      check("t6b_blocks", 64'(blocks_done_o), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
